serial_paralelo_param: RTL and testbench
========================================

// Module: serial_paralelo_param
// PURPOSE
//  Parametrised receive-side deserializer for the serial PHY lane. Samples one bit per clk_32f edge, MSB first.
//  It hunts for the COM symbol at any bit offset and locks word alignment after SYNC_COUNT consecutive aligned COMs.
//  In lock it emits payload words with a one-cycle valid strobe. New over the fixed 8-bit block: generic WIDTH and
//  symbols, a single clock with an internal word counter, and loss-of-sync detection with automatic re-hunt.
// PARAMETERS
//  WIDTH       8      bits per word / parallel output width (>=4)
//  COM         8'hBC  comma/alignment symbol (WIDTH bits)
//  IDL         8'h7C  idle symbol; received in lock but never flagged valid
//  SYNC_COUNT  4      consecutive word-aligned COMs needed to assert active (>=1)
//  LOSS_COUNT  2      consecutive misaligned COMs in lock that drop sync (>=1)
// PORTS
//  clk_32f    in   1      single bit-rate clock; all state on rising edge
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  data_in    in   1      serial bit, sampled every clk_32f rising edge
//  data_out   out  WIDTH  last word captured while locked; held between captures
//  valid_out  out  1      1-cycle pulse: data_out updated with a payload word (not COM, not IDL)
//  active     out  1      1 while state==LOCKED
//  sync_lost  out  1      1-cycle pulse on the LOCKED->HUNT transition
// BEHAVIOUR
//  - Reset (async, reset==0): state=HUNT, sr=0, bit_cnt=0, com_cnt=0, miss_cnt=0; data_out=0, valid_out=0,
//    active=0, sync_lost=0. Reset mid-word or mid-lock discards everything; hunting restarts at the first edge after release.
//  - word_next = {sr[WIDTH-2:0], data_in}. Every edge: sr <= word_next. All decisions below use word_next.
//  - boundary = (bit_cnt==WIDTH-1) in ALIGN/LOCKED. bit_cnt increments every edge and wraps to 0 at boundary.
//  - HUNT: when word_next==COM: bit_cnt<=0 (this edge is a word boundary), com_cnt<=1, and ->ALIGN.
//    If SYNC_COUNT==1, go ->LOCKED instead and assert active on the same edge.
//  - ALIGN: at boundary, if word_next==COM: com_cnt++; when com_cnt+1==SYNC_COUNT ->LOCKED, active<=1.
//    At boundary with word_next!=COM: ->HUNT, com_cnt<=0. No output activity in ALIGN.
//  - LOCKED, at boundary: data_out<=word_next for every word (COM/IDL included).
//    valid_out<=1 only if word_next is neither COM nor IDL; else 0. An aligned COM clears miss_cnt.
//  - LOCKED, off boundary: word_next==COM is a misaligned comma: miss_cnt++.
//    When miss_cnt+1==LOSS_COUNT: ->HUNT, active<=0, sync_lost<=1 for one cycle, miss_cnt<=0, com_cnt<=0.
//    data_out holds its value; valid_out<=0.
//  - Loss edge: the misaligned COM that triggers loss is not reused as a new HUNT hit; hunting starts next edge.
//  - valid_out and sync_lost default to 0 on every edge unless set above. Latency: valid_out/data_out update on the
//    same edge that samples the word's last bit; one payload word every WIDTH cycles at most.
//  - Counters: bit_cnt is $clog2(WIDTH) bits; com_cnt and miss_cnt saturate-free, sized to their parameter.
// STRUCTURE
//  - Shared include phy_defs.vh: default COM/IDL symbols, state encodings HUNT=2'd0, ALIGN=2'd1, LOCKED=2'd2.
//  - One sub-module, comma_detector: WIDTH-bit shift register plus COM/IDL comparators on word_next.
//    Top level keeps the FSM, counters and output registers.
//  - The synthesised netlist (serial_paralelo_param_synth) must match the behavioural model cycle-for-cycle.
// TESTING (WIDTH=8 unless noted; compare behavioural vs synth outputs every cycle)
//  1. Reset low for 3 cycles, then stream 4x 8'hBC at offset 0 -> active rises on the edge sampling the last bit
//     of the 4th BC; valid_out stays 0.
//  2. Locked, send 8'h3A, 8'h7C, 8'hBC, 8'h05 -> data_out = 3A,7C,BC,05 at successive boundaries;
//     valid_out pulses only for 3A and 05.
//  3. 3 garbage bits, then 4x BC -> lock at bit offset 3. A non-BC word after 2 BCs in ALIGN returns to HUNT,
//     and active stays 0.
//  4. Locked with LOSS_COUNT=2, inject BC shifted by 1 bit twice -> sync_lost pulses once, active=0, data_out held.
//     Then 4 aligned BCs relock.
//  5. Drive reset=0 mid-word while locked -> all outputs 0 immediately (asynchronous), with no clock edge needed.
//  6. WIDTH=10, COM=10'h17C, SYNC_COUNT=1 -> the first COM locks; payload 10'h2A5 gives valid_out with data_out=2A5.

Source files
------------

// File: rtl/serial_paralelo_param_pkg.sv
// Shared definitions for the serial PHY receive deserializer: FSM state
// encoding, default line symbols and a counter-sizing helper.
package serial_paralelo_param_pkg;

    // Word-alignment FSM states; the encoding is fixed so that other blocks
    // on the lane can decode it.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

    // Default 8-bit comma and idle symbols.
    localparam logic [7:0] PHY_COM_DEFAULT = 8'hBC;
    localparam logic [7:0] PHY_IDL_DEFAULT = 8'h7C;

    // Number of bits needed to hold the values 0..max_val.
    function automatic int cnt_bits(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/comma_detector.sv
// Serial-in shift register with COM / IDL comparators. word_next is the word
// formed by the stored bits plus the bit sampled on this edge.
module comma_detector
    import serial_paralelo_param_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COM   = WIDTH'(PHY_COM_DEFAULT),
    parameter logic [WIDTH-1:0] IDL   = WIDTH'(PHY_IDL_DEFAULT)
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] word_next,
    output logic             is_com,
    output logic             is_idl
);

    // The oldest bit falls out of word_next on the next edge, so only the
    // newest WIDTH-1 bits need storing.
    logic [WIDTH-2:0] sr;

    assign word_next = {sr, data_in};
    assign is_com    = (word_next == COM);
    assign is_idl    = (word_next == IDL);

    // Shift one bit in per edge, MSB first; cleared on reset.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr <= word_next[WIDTH-2:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_param.sv
// Receive-side deserializer for the serial PHY lane. Hunts for COM at any bit
// offset, locks word alignment after SYNC_COUNT aligned COMs, emits payload
// words with a one-cycle valid strobe and drops back to hunting after
// LOSS_COUNT consecutive misaligned COMs.
module serial_paralelo_param
    import serial_paralelo_param_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(PHY_COM_DEFAULT),
    parameter logic [WIDTH-1:0] IDL        = WIDTH'(PHY_IDL_DEFAULT),
    parameter int               SYNC_COUNT = 4,
    parameter int               LOSS_COUNT = 2
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic             sync_lost
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = cnt_bits(SYNC_COUNT);
    localparam int MW = cnt_bits(LOSS_COUNT);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    sync_state_e      state;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    com_cnt;
    logic [MW-1:0]    miss_cnt;

    logic [WIDTH-1:0] word_next;
    logic             is_com;
    logic             is_idl;
    logic             boundary;
    logic             sync_reached;
    logic             loss_reached;

    comma_detector #(
        .WIDTH (WIDTH),
        .COM   (COM),
        .IDL   (IDL)
    ) u_comma_detector (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .word_next (word_next),
        .is_com    (is_com),
        .is_idl    (is_idl)
    );

    // Only meaningful in ALIGN/LOCKED; in HUNT the counter free-runs and is
    // re-zeroed on the COM hit that defines the word boundary.
    assign boundary     = (bit_cnt == LAST_BIT);
    assign sync_reached = (int'(com_cnt) + 1) == SYNC_COUNT;
    assign loss_reached = (int'(miss_cnt) + 1) == LOSS_COUNT;

    // Alignment FSM, counters and registered outputs in one clocked process.
    // NOTE: every assignment here is non-blocking so all decisions on an edge
    // see the pre-edge values, matching the flop behaviour in hardware.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            miss_cnt  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
            sync_lost <= 1'b0;
        end else begin
            // NOTE: pulses default low here and are raised below only on the
            // edge that produces them, which makes them exactly one cycle wide.
            valid_out <= 1'b0;
            sync_lost <= 1'b0;
            bit_cnt   <= boundary ? '0 : bit_cnt + BW'(1);

            case (state)
                HUNT: begin
                    if (is_com) begin
                        // This edge completes a COM, so it is a word boundary.
                        bit_cnt <= '0;
                        com_cnt <= CW'(1);
                        if (SYNC_COUNT == 1) begin
                            state  <= LOCKED;
                            active <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt <= com_cnt + CW'(1);
                            if (sync_reached) begin
                                state  <= LOCKED;
                                active <= 1'b1;
                            end
                        end else begin
                            state   <= HUNT;
                            com_cnt <= '0;
                        end
                    end
                end

                LOCKED: begin
                    if (boundary) begin
                        data_out  <= word_next;
                        valid_out <= !is_com && !is_idl;
                        if (is_com) begin
                            miss_cnt <= '0;
                        end
                    end else if (is_com) begin
                        // Comma seen off the word grid: alignment is suspect.
                        if (loss_reached) begin
                            state     <= HUNT;
                            active    <= 1'b0;
                            sync_lost <= 1'b1;
                            miss_cnt  <= '0;
                            com_cnt   <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + MW'(1);
                        end
                    end
                end

                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Directed bench for serial_paralelo_param: an 8-bit instance (SYNC_COUNT=4,
// LOSS_COUNT=2) and a 10-bit instance with SYNC_COUNT=1 sharing clock/reset.
module tb_serial_paralelo_param;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       din8    = 1'b0;
    logic       din10   = 1'b0;

    logic [7:0] dout8;
    logic       v8, a8, s8;
    logic [9:0] dout10;
    logic       v10, a10, s10;

    int checks = 0;
    int errors = 0;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_param dut8 (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (din8),
        .data_out  (dout8),
        .valid_out (v8),
        .active    (a8),
        .sync_lost (s8)
    );

    serial_paralelo_param #(
        .WIDTH      (10),
        .COM        (10'h17C),
        .SYNC_COUNT (1)
    ) dut10 (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (din10),
        .data_out  (dout10),
        .valid_out (v10),
        .active    (a10),
        .sync_lost (s10)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect8(input string tag, input logic [7:0] d, input logic v,
                           input logic a, input logic s);
        check({tag, ".data"},  16'(dout8), 16'(d));
        check({tag, ".valid"}, 16'(v8),    16'(v));
        check({tag, ".active"},16'(a8),    16'(a));
        check({tag, ".lost"},  16'(s8),    16'(s));
    endtask

    task automatic expect10(input string tag, input logic [9:0] d, input logic v,
                            input logic a, input logic s);
        check({tag, ".data"},  16'(dout10), 16'(d));
        check({tag, ".valid"}, 16'(v10),    16'(v));
        check({tag, ".active"},16'(a10),    16'(a));
        check({tag, ".lost"},  16'(s10),    16'(s));
    endtask

    // Drive one bit, let one rising edge sample it, then settle past the edge.
    task automatic send_bit8(input logic b);
        din8 = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_bits8(input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit8(w[i]);
    endtask

    task automatic send8(input logic [7:0] w);
        send_bits8(w, 7, 0);
    endtask

    task automatic send10(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) begin
            din10 = w[i];
            @(posedge clk_32f);
            #1;
        end
    endtask

    initial begin
        // Reset held low for three edges.
        reset = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        expect8("reset8", 8'h00, 1'b0, 1'b0, 1'b0);
        expect10("reset10", 10'h000, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Four aligned commas at offset 0; lock on the last bit of the 4th.
        for (int n = 0; n < 3; n++) begin
            send8(8'hBC);
            expect8("t1.align", 8'h00, 1'b0, 1'b0, 1'b0);
        end
        send_bits8(8'hBC, 7, 1);
        check("t1.prelock.active", 16'(a8), 16'h0);
        send_bit8(1'b0);
        expect8("t1.lock", 8'h00, 1'b0, 1'b1, 1'b0);

        // Payload / idle / comma / payload while locked.
        send8(8'h3A);
        expect8("t2.3A", 8'h3A, 1'b1, 1'b1, 1'b0);
        send_bit8(1'b0);
        expect8("t2.pulse_end", 8'h3A, 1'b0, 1'b1, 1'b0);
        send_bits8(8'h7C, 6, 0);
        expect8("t2.7C", 8'h7C, 1'b0, 1'b1, 1'b0);
        send8(8'hBC);
        expect8("t2.BC", 8'hBC, 1'b0, 1'b1, 1'b0);
        send8(8'h05);
        expect8("t2.05", 8'h05, 1'b1, 1'b1, 1'b0);

        // Two commas shifted by one bit; the boundary words become 5E.
        send_bit8(1'b0);
        send_bits8(8'hBC, 7, 1);
        expect8("t4.word5E_a", 8'h5E, 1'b1, 1'b1, 1'b0);
        send_bit8(1'b0);
        expect8("t4.miss1", 8'h5E, 1'b0, 1'b1, 1'b0);
        send_bits8(8'hBC, 7, 1);
        expect8("t4.word5E_b", 8'h5E, 1'b1, 1'b1, 1'b0);
        send_bit8(1'b0);
        expect8("t4.loss", 8'h5E, 1'b0, 1'b0, 1'b1);
        send_bit8(1'b1);
        expect8("t4.lost_end", 8'h5E, 1'b0, 1'b0, 1'b0);
        send_bits8(8'hBC, 6, 0);
        for (int n = 0; n < 2; n++) begin
            send8(8'hBC);
            check("t4.realign.active", 16'(a8), 16'h0);
        end
        send8(8'hBC);
        expect8("t4.relock", 8'h5E, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-word while locked, away from any edge.
        send_bits8(8'hA0, 7, 5);
        reset = 1'b0;
        #1;
        expect8("t5.async", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b1;

        // Lock at bit offset 3, with a broken ALIGN sequence first.
        send_bits8(8'hC0, 7, 5);
        send8(8'hBC);
        send8(8'hBC);
        check("t3.align.active", 16'(a8), 16'h0);
        send8(8'h00);
        expect8("t3.rehunt", 8'h00, 1'b0, 1'b0, 1'b0);
        send8(8'hBC);
        send8(8'hBC);
        check("t3.no_lock.active", 16'(a8), 16'h0);
        send8(8'hBC);
        send8(8'hBC);
        expect8("t3.lock", 8'h00, 1'b0, 1'b1, 1'b0);
        send8(8'h5A);
        expect8("t3.5A", 8'h5A, 1'b1, 1'b1, 1'b0);

        // 10-bit lane, single comma locks.
        send10(10'h17C);
        expect10("t6.lock", 10'h000, 1'b0, 1'b1, 1'b0);
        send10(10'h2A5);
        expect10("t6.2A5", 10'h2A5, 1'b1, 1'b1, 1'b0);
        din10 = 1'b0;
        @(posedge clk_32f);
        #1;
        expect10("t6.pulse_end", 10'h2A5, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
